ram_io_responder: RTL and testbench
===================================

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 SHALL use parameter RAM_AW, default 17, giving a RAM of 2^RAM_AW bytes at mem_a[RAM_AW-1:0].
REQ-002 SHALL use parameter FIFO_DEPTH, default 8, a power of two, as the depth of each IO FIFO.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mem_a, input, 32 bits: byte address from the memory controller; only bits [17:0] are decoded.
REQ-006 SHALL have port mem_dout, input, 8 bits: write data from the controller.
REQ-007 SHALL have port mem_wr, input, 1 bit: 1 = write this cycle, 0 = read.
REQ-008 SHALL have port mem_din, output, 8 bits: registered read data returned to the controller.
REQ-009 SHALL have ports io_tx_data (output, 8), io_tx_valid (output, 1) and io_tx_ready (input, 1): the outbound byte stream.
REQ-010 SHALL have ports io_rx_data (input, 8), io_rx_valid (input, 1) and io_rx_ready (output, 1): the inbound byte stream.

Function
REQ-011 SHALL decode mem_a[17]=0 as RAM and mem_a[17]=1 as IO; IO offset = mem_a[2:0].
REQ-012 On a RAM write (mem_wr=1), it SHALL store mem_dout at mem_a[RAM_AW-1:0] at the clock edge.
REQ-013 On a RAM read (mem_wr=0), it SHALL drive mem_din with the addressed byte one cycle later.
REQ-014 On a RAM write cycle, it SHALL drive mem_din with the old content of the written byte on the next cycle (read-before-write).
REQ-015 A write to IO offset 0 (0x30000) SHALL push mem_dout into TX FIFO once per cycle with mem_wr=1.
REQ-016 If TX FIFO is full, the push SHALL be dropped and sticky flag tx_ovf set, unless the FIFO drains the same cycle, in which case the push SHALL be accepted and the count stays at FIFO_DEPTH.
REQ-017 A write to IO offset 4 with mem_dout[0]=1 SHALL clear tx_ovf.
REQ-018 Writes to other IO offsets SHALL be ignored.
REQ-019 A read of IO offset 0 SHALL pop RX FIFO and return its head byte on mem_din next cycle, but only on the entry cycle.
REQ-020 The entry cycle SHALL be a cycle where mem_a differs from the previous cycle's registered mem_a, or where the previous cycle was a write.
REQ-021 While the same address is held on later read cycles, it SHALL NOT pop again and mem_din SHALL hold the byte returned at entry.
REQ-022 A read of IO offset 0 with RX FIFO empty SHALL return 0x00 and SHALL NOT pop.
REQ-023 A read of IO offset 4 SHALL return the status byte {5'b0, tx_ovf, tx_full, rx_nonempty}.
REQ-024 Reads of other IO offsets SHALL return 0x00.
REQ-025 SHALL drive io_tx_valid = TX FIFO non-empty and io_tx_data = TX head.
REQ-026 SHALL pop TX FIFO on io_tx_valid & io_tx_ready.
REQ-027 SHALL drive io_rx_ready = RX FIFO not full.
REQ-028 SHALL push io_rx_data into RX FIFO on io_rx_valid & io_rx_ready.
REQ-029 A simultaneous push and pop on either FIFO SHALL both take effect, leaving the count unchanged.
REQ-030 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 FIFO counts SHALL be log2(FIFO_DEPTH)+1 bits wide and SHALL never exceed FIFO_DEPTH or go below 0.

Reset
REQ-032 While rst_in=0, it SHALL asynchronously empty both FIFOs (pointers and counts 0) and clear tx_ovf.
REQ-033 While rst_in=0, it SHALL force mem_din=0x00, io_tx_valid=0 and io_rx_ready=0.
REQ-034 While rst_in=0, it SHALL set the previous-address register to 0xFFFFFFFF and the previous-write flag to 0.
REQ-035 RAM contents SHALL NOT be reset.
REQ-036 On reset release, io_rx_ready SHALL rise on the first clock edge.
REQ-037 A reset asserted mid-transfer SHALL discard all FIFO contents.

Verification
REQ-038 Write 0xA5 to 0x00010, then hold a read of 0x00010 for 2 cycles -> mem_din=0xA5 from the cycle after the address is first presented.
REQ-039 Feed io_rx bytes 0x11,0x22, then read 0x30000 held for 3 cycles, then move the address, then read 0x30000 again -> mem_din 0x11 held for all 3 cycles, then 0x22; exactly 2 pops.
REQ-040 With io_tx_ready=0, perform 9 writes to 0x30000 -> 8 bytes queued; status read at 0x30004 returns 0x06; write 0x01 to 0x30004 -> status returns 0x02.
REQ-041 With TX FIFO full and io_tx_ready=1, write 0x5A in the same cycle -> push accepted, tx_ovf stays 0, 0x5A emerges last.
REQ-042 Read 0x30000 with RX FIFO empty -> mem_din=0x00; then assert rst_in=0 mid-stream with 3 TX bytes queued -> io_tx_valid=0 immediately and status returns 0x00 after release.

Source files
------------

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte RAM plus a small memory-mapped IO window.
//   mem_a[17] = 0 : RAM byte at mem_a[RAM_AW-1:0], registered read, read-before-write.
//   mem_a[17] = 1 : IO window, offset mem_a[2:0]
//     offset 0  write -> push TX FIFO, read -> pop RX FIFO (only on the entry cycle)
//     offset 4  write bit0=1 -> clear tx_ovf, read -> {5'b0, tx_ovf, tx_full, rx_nonempty}
// An "entry" cycle is one whose address differs from the previous cycle's
// address, or that follows a write. A held read therefore pops RX only once.
module ram_io_responder #(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  // address decode
  logic              ram_sel;
  logic              io_sel;
  logic [RAM_AW-1:0] ram_a;
  logic [2:0]        io_off;
  logic              entry;

  // access history used to detect entry cycles
  logic [31:0] prev_a_q;
  logic        prev_wr_q;

  // RAM and read-data path
  logic [7:0] ram [2**RAM_AW];
  logic [7:0] ram_rd_q;
  logic       sel_ram_q;
  logic [7:0] io_rd_q;
  logic [7:0] io_rd_d;

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp_q, tx_rp_q;
  logic [CW-1:0] tx_cnt_q;
  logic          tx_full;
  logic          tx_wr_req;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_ovf_q;
  logic          ovf_set;
  logic          ovf_clr;

  // RX FIFO
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp_q, rx_rp_q;
  logic [CW-1:0] rx_cnt_q;
  logic          rx_full;
  logic          rx_nonempty;
  logic          rx_push;
  logic          rx_pop;
  logic          rx_en_q;

  logic [7:0] status;

  assign ram_sel = ~mem_a[17];
  assign io_sel  = mem_a[17];
  assign ram_a   = mem_a[RAM_AW-1:0];
  assign io_off  = mem_a[2:0];
  assign entry   = prev_wr_q | (mem_a != prev_a_q);

  assign tx_full     = (tx_cnt_q == CNT_FULL);
  assign io_tx_valid = (tx_cnt_q != '0);
  assign io_tx_data  = tx_mem[tx_rp_q];
  assign tx_pop      = io_tx_valid & io_tx_ready;
  assign tx_wr_req   = io_sel & mem_wr & (io_off == 3'd0);
  // a full FIFO still accepts the push when it drains in the same cycle
  assign tx_push     = tx_wr_req & (~tx_full | tx_pop);
  assign ovf_set     = tx_wr_req & tx_full & ~tx_pop;
  assign ovf_clr     = io_sel & mem_wr & (io_off == 3'd4) & mem_dout[0];

  assign rx_full     = (rx_cnt_q == CNT_FULL);
  assign rx_nonempty = (rx_cnt_q != '0);
  // rx_en_q keeps ready low through reset and raises it on the first edge after
  assign io_rx_ready = rx_en_q & ~rx_full;
  assign rx_push     = io_rx_valid & io_rx_ready;
  assign rx_pop      = io_sel & ~mem_wr & (io_off == 3'd0) & entry & rx_nonempty;

  assign status  = {5'b0, tx_ovf_q, tx_full, rx_nonempty};
  assign mem_din = sel_ram_q ? ram_rd_q : io_rd_q;

  // RAM array and its read register; contents are deliberately not reset
  always_ff @(posedge clk_in) begin
    if (ram_sel && mem_wr) begin
      ram[ram_a] <= mem_dout;
    end
    ram_rd_q <= ram[ram_a];
  end

  // IO read data for next cycle; a held RX read keeps the byte from entry
  always_comb begin
    io_rd_d = 8'h00;
    if (io_sel && !mem_wr) begin
      case (io_off)
        3'd0: begin
          if (!entry) begin
            io_rd_d = io_rd_q;
          end else if (rx_nonempty) begin
            io_rd_d = rx_mem[rx_rp_q];
          end
        end
        3'd4:    io_rd_d = status;
        default: io_rd_d = 8'h00;
      endcase
    end
  end

  // read-path select, IO read register and access history
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_ram_q <= 1'b0;
      io_rd_q   <= 8'h00;
      prev_a_q  <= 32'hFFFF_FFFF;
      prev_wr_q <= 1'b0;
      rx_en_q   <= 1'b0;
    end else begin
      sel_ram_q <= ram_sel;
      io_rd_q   <= io_rd_d;
      prev_a_q  <= mem_a;
      prev_wr_q <= mem_wr;
      rx_en_q   <= 1'b1;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk_in) begin
    if (tx_push) begin
      tx_mem[tx_wp_q] <= mem_dout;
    end
  end

  // TX FIFO pointers, count and sticky overflow flag
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (tx_push && !tx_pop) begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end else if (!tx_push && tx_pop) begin
        tx_cnt_q <= tx_cnt_q - 1'b1;
      end
      if (ovf_set) begin
        tx_ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        tx_ovf_q <= 1'b0;
      end
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk_in) begin
    if (rx_push) begin
      rx_mem[rx_wp_q] <= io_rx_data;
    end
  end

  // RX FIFO pointers and count
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      if (rx_push && !rx_pop) begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end else if (!rx_push && rx_pop) begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder with a scoreboard: the driver queues the
// expected mem_din byte (due one cycle later) and expected TX bytes; monitors
// on the falling edge pop and compare.
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] mem_a = 32'h0;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready = 1'b0;
  logic [7:0]  io_rx_data = 8'h00;
  logic        io_rx_valid = 1'b0;
  logic        io_rx_ready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [7:0] val;
    string      nm;
  } rd_t;

  rd_t        rd_q[$];
  logic [7:0] tx_exp[$];

  ram_io_responder dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .mem_a       (mem_a),
    .mem_dout    (mem_dout),
    .mem_wr      (mem_wr),
    .mem_din     (mem_din),
    .io_tx_data  (io_tx_data),
    .io_tx_valid (io_tx_valid),
    .io_tx_ready (io_tx_ready),
    .io_rx_data  (io_rx_data),
    .io_rx_valid (io_rx_valid),
    .io_rx_ready (io_rx_ready)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mem(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
  endtask

  task automatic expect_rd(input logic [7:0] v, input string nm);
    rd_t e;
    e.due = cyc + 1;
    e.val = v;
    e.nm  = nm;
    rd_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // read-data monitor: compare mem_din against queued expectations when due
  always @(negedge clk_in) begin
    rd_t e;
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      e = rd_q.pop_front();
      checks++;
      if (e.due != cyc) begin
        failures++;
        $display("FAIL %s_late cycle actual=%0d required=%0d", e.nm, cyc, e.due);
      end else if (mem_din !== e.val) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.nm, mem_din, e.val);
      end
    end
  end

  // TX stream monitor: every handshake must match the next queued byte
  always @(negedge clk_in) begin
    logic [7:0] exp;
    if (io_tx_valid && io_tx_ready) begin
      checks++;
      if (tx_exp.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected actual=%h required=none", io_tx_data);
      end else begin
        exp = tx_exp.pop_front();
        if (io_tx_data !== exp) begin
          failures++;
          $display("FAIL tx_data actual=%h required=%h", io_tx_data, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset and its release behaviour
    #1 rst_in = 1'b0;
    #10;
    check("rst_mem_din", mem_din, 8'h00);
    check("rst_tx_valid", {7'b0, io_tx_valid}, 8'h00);
    check("rst_rx_ready", {7'b0, io_rx_ready}, 8'h00);
    step();
    rst_in = 1'b1;
    #1;
    check("rx_ready_before_edge", {7'b0, io_rx_ready}, 8'h00);
    step();
    check("rx_ready_first_edge", {7'b0, io_rx_ready}, 8'h01);

    // RAM write, held read, read-before-write
    step(); mem(32'h10, 1'b1, 8'hA5);
    step(); mem(32'h10, 1'b0, 8'h00); expect_rd(8'hA5, "ram_rd0");
    step();                            expect_rd(8'hA5, "ram_rd1");
    step(); mem(32'h10, 1'b1, 8'h3C); expect_rd(8'hA5, "ram_rbw");
    step(); mem(32'h10, 1'b0, 8'h00); expect_rd(8'h3C, "ram_new");
    step(); mem(32'h20, 1'b1, 8'h5C);
    step(); mem(32'h20, 1'b0, 8'h00); expect_rd(8'h5C, "ram_b");
    step(); mem(32'h10, 1'b0, 8'h00); expect_rd(8'h3C, "ram_a_kept");

    // RX: two bytes in, held read pops once, moved address pops again
    step(); mem(32'h0, 1'b0, 8'h00); io_rx_valid = 1'b1; io_rx_data = 8'h11;
    step(); io_rx_data = 8'h22;
    step(); io_rx_valid = 1'b0;
    step(); mem(32'h30000, 1'b0, 8'h00); expect_rd(8'h11, "rx_hold0");
    step();                               expect_rd(8'h11, "rx_hold1");
    step();                               expect_rd(8'h11, "rx_hold2");
    step(); mem(32'h30004, 1'b0, 8'h00); expect_rd(8'h01, "stat_one_left");
    step(); mem(32'h30000, 1'b0, 8'h00); expect_rd(8'h22, "rx_second");
    step(); mem(32'h30004, 1'b0, 8'h00); expect_rd(8'h00, "stat_rx_empty");
    step(); mem(32'h30000, 1'b0, 8'h00); expect_rd(8'h00, "rx_empty_rd");
    step();                               expect_rd(8'h00, "rx_empty_hold");

    // TX: overflow with ready low, ignored offset, clear, drain-while-full push
    io_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(); mem(32'h30000, 1'b1, 8'h80 + 8'(i));
      if (i < 8) tx_exp.push_back(8'h80 + 8'(i));
    end
    step(); mem(32'h30004, 1'b0, 8'h00); expect_rd(8'h06, "stat_ovf");
    step(); mem(32'h30005, 1'b1, 8'h01);
    step(); mem(32'h30004, 1'b0, 8'h00); expect_rd(8'h06, "stat_ign_wr");
    step(); mem(32'h30002, 1'b0, 8'h00); expect_rd(8'h00, "off2_rd");
    step(); mem(32'h30004, 1'b1, 8'h01);
    step(); mem(32'h30004, 1'b0, 8'h00); expect_rd(8'h02, "stat_clr");
    step(); io_tx_ready = 1'b1; mem(32'h30000, 1'b1, 8'h5A); tx_exp.push_back(8'h5A);
    step(); mem(32'h30004, 1'b0, 8'h00); expect_rd(8'h02, "stat_full_drain");
    for (int i = 0; i < 9; i++) begin
      step(); mem(32'h0, 1'b0, 8'h00);
    end
    step(); mem(32'h30004, 1'b0, 8'h00); expect_rd(8'h00, "stat_drained");
    step(); io_tx_ready = 1'b0; mem(32'h0, 1'b0, 8'h00);

    // reset mid-stream discards queued TX and RX bytes, RAM survives
    step(); mem(32'h30000, 1'b1, 8'hD1);
    step(); mem(32'h30000, 1'b1, 8'hD2);
    step(); mem(32'h30000, 1'b1, 8'hD3);
    step(); mem(32'h0, 1'b0, 8'h00); io_rx_valid = 1'b1; io_rx_data = 8'h99;
    step(); io_rx_valid = 1'b0;
    check("tx_valid_pre_rst", {7'b0, io_tx_valid}, 8'h01);
    #2 rst_in = 1'b0;
    #1;
    check("tx_valid_in_rst", {7'b0, io_tx_valid}, 8'h00);
    check("rx_ready_in_rst", {7'b0, io_rx_ready}, 8'h00);
    check("mem_din_in_rst", mem_din, 8'h00);
    step();
    step(); rst_in = 1'b1;
    step(); mem(32'h30004, 1'b0, 8'h00); expect_rd(8'h00, "stat_post_rst");
    step(); mem(32'h30000, 1'b0, 8'h00); expect_rd(8'h00, "rx_discarded");
    step(); mem(32'h20, 1'b0, 8'h00);    expect_rd(8'h5C, "ram_survives");
    step(); io_tx_ready = 1'b1; mem(32'h0, 1'b0, 8'h00);
    step();
    step();
    step(); io_tx_ready = 1'b0;
    step();
    step();

    checks++;
    if (rd_q.size() != 0) begin
      failures++;
      $display("FAIL rd_leftover actual=%0d required=0", rd_q.size());
    end
    checks++;
    if (tx_exp.size() != 0) begin
      failures++;
      $display("FAIL tx_leftover actual=%0d required=0", tx_exp.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
